// File: rtl/ysyx_24080014_mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encodings and operand-signedness helpers.
package ysyx_24080014_mdu_pkg;

    // funct3 encodings of the M-extension ops
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // funct3[2] separates divide/remainder from multiply
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // funct3[1] within the divide group selects the remainder
    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // src1 is treated as signed for every op except the fully unsigned ones
    function automatic logic src1_signed(input logic [2:0] op);
        return !(op == MDU_MULHU || op == MDU_DIVU || op == MDU_REMU);
    endfunction

    // src2 is additionally unsigned for MULHSU
    function automatic logic src2_signed(input logic [2:0] op);
        return !(op == MDU_MULHU || op == MDU_MULHSU || op == MDU_DIVU || op == MDU_REMU);
    endfunction

endpackage

// File: rtl/ysyx_24080014_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module ysyx_24080014_mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quo_bit_o
);

    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    // Trial subtraction; the top bit of the difference is the borrow
    always_comb begin
        partial   = {rem_i, dividend_bit_i};
        diff      = partial - {1'b0, divisor_i};
        quo_bit_o = ~diff[XLEN];
        // rem_i < divisor, so partial < 2*divisor and either branch fits XLEN bits
        rem_o     = quo_bit_o ? diff[XLEN-1:0] : partial[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_24080014_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit. Both operations run on
// operand magnitudes in a shared 2*XLEN accumulator; the sign is applied in
// the final cycle. Divide-by-zero and signed overflow complete immediately.
module ysyx_24080014_mdu
    import ysyx_24080014_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;      // {product hi, lo} or {remainder, quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;      // result must be negated at fix-up
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-side decode of the incoming request
    logic            s1_neg, s2_neg;
    logic [XLEN-1:0] s1_mag, s2_mag;
    logic            div_by_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_result;
    logic            req_neg;

    // Sign/magnitude split and fast-path detection
    always_comb begin
        s1_neg      = src1_signed(op) & src1[XLEN-1];
        s2_neg      = src2_signed(op) & src2[XLEN-1];
        // Negating the most negative value yields 2^(XLEN-1), correct as unsigned
        s1_mag      = s1_neg ? (~src1 + 1'b1) : src1;
        s2_mag      = s2_neg ? (~src2 + 1'b1) : src2;
        div_by_zero = op_is_div(op) && (src2 == '0);
        div_ovf     = (op == MDU_DIV || op == MDU_REM)
                      && (src1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (src2 == '1);
        fast        = div_by_zero | div_ovf;
        if (div_by_zero) begin
            fast_result = op_is_rem(op) ? src1 : '1;
        end else begin
            fast_result = op_is_rem(op) ? '0 : src1;
        end
        // Remainder follows the dividend; products and quotients follow the sign XOR
        req_neg = op_is_rem(op) ? s1_neg : (s1_neg ^ s2_neg);
    end

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem;
    logic              div_qbit;
    logic [2*XLEN-1:0] div_next;

    ysyx_24080014_mdu_divstep #(
        .XLEN(XLEN)
    ) u_divstep (
        .rem_i          (acc_q[2*XLEN-1:XLEN]),
        .dividend_bit_i (acc_q[XLEN-1]),
        .divisor_i      (opnd_q),
        .rem_o          (div_rem),
        .quo_bit_o      (div_qbit)
    );

    // Add-shift multiply step and shift-in of the quotient bit
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};
    end

    // Final sign fix-up and result selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                      final_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_result = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:            final_result = quo_fix;
            default:                      final_result = rem_fix;
        endcase
    end

    // Next-state logic: flush overrides both accept and completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d  = op;
                        neg_d = req_neg;
                        if (fast) begin
                            result_d = fast_result;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = '0;
                            opnd_d  = op_is_div(op) ? s2_mag : s1_mag;
                            acc_d   = {{XLEN{1'b0}}, (op_is_div(op) ? s1_mag : s2_mag)};
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        result_d = final_result;
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                    end else begin
                        acc_d = op_is_div(op_q) ? div_next : mul_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_ysyx_24080014_mdu.sv
// Directed bench for the multiply/divide unit: a table of ops with
// hand-computed results and latencies, plus backpressure, flush and
// mid-op reset sequences.
module tb_ysyx_24080014_mdu;
    import ysyx_24080014_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ysyx_24080014_mdu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;   // posedges after the accept edge until out_valid
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op, wait (bounded) for its result, check it, then consume it.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        op = v.op; src1 = v.a; src2 = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " result"}, result, v.exp);
        $display("%s op=%0d a=0x%08h b=0x%08h -> 0x%08h after %0d clk", tag, v.op, v.a, v.b, result, lat);
        @(posedge clk); #1;
        chk({tag, " release"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{MDU_MUL,    32'd7,          32'd6,          32'h0000002A, 33};
        vecs[1]  = '{MDU_MULH,   32'h80000000,   32'h80000000,   32'h40000000, 33};
        vecs[2]  = '{MDU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33};
        vecs[3]  = '{MDU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 33};
        vecs[4]  = '{MDU_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33};
        vecs[5]  = '{MDU_MULH,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 33};
        vecs[6]  = '{MDU_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 33};
        vecs[7]  = '{MDU_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 33};
        vecs[8]  = '{MDU_DIVU,   32'd100,        32'd7,          32'd14,       33};
        vecs[9]  = '{MDU_REMU,   32'd100,        32'd7,          32'd2,        33};
        vecs[10] = '{MDU_DIV,    32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 33};
        vecs[11] = '{MDU_REM,    32'd7,          32'hFFFFFFFE,   32'd1,        33};
        vecs[12] = '{MDU_DIV,    32'h80000000,   32'd1,          32'h80000000, 33};
        vecs[13] = '{MDU_DIV,    32'hFFFFFFFD,   32'd7,          32'd0,        33};
        vecs[14] = '{MDU_REM,    32'hFFFFFFFD,   32'd7,          32'hFFFFFFFD, 33};
        // fast path: completes on the accept edge itself
        vecs[15] = '{MDU_DIVU,   32'd5,          32'd0,          32'hFFFFFFFF, 0};
        vecs[16] = '{MDU_REM,    32'd5,          32'd0,          32'd5,        0};
        vecs[17] = '{MDU_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000, 0};
        vecs[18] = '{MDU_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,        0};
        vecs[19] = '{MDU_REMU,   32'hFFFFFFF0,   32'd0,          32'hFFFFFFF0, 0};

        // Reset values while rst is held
        #2;
        chk("reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset result",    result,             32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // flush at iteration 10: back to IDLE next clock, no result ever
        @(negedge clk);
        op = MDU_DIVU; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready",  {31'd0, in_ready},  32'd1);
        chk("flush busy",      {31'd0, busy},      32'd0);
        // flush together with a request: not accepted
        @(negedge clk);
        op = MDU_MUL; src1 = 32'd2; src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush blocks accept", {31'd0, busy}, 32'd0);
        @(negedge clk); in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("flush no result", seen, 0);
        $display("flush sequence done");

        // rst pulse at iteration 20: immediate reset values
        @(negedge clk);
        op = MDU_DIVU; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst busy",      {31'd0, busy},      32'd0);
        chk("midrst result",    result,             32'd0);
        @(negedge clk); rst = 1'b0;
        $display("mid-op reset sequence done");
        run_vec('{MDU_DIVU, 32'd9, 32'd3, 32'd3, 33}, "post-rst");

        // Backpressure: result held for 5 clocks while a new request waits
        out_ready = 1'b0;
        @(negedge clk);
        op = MDU_MUL; src1 = 32'd3; src2 = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        op = MDU_DIVU; src1 = 32'd9; src2 = 32'd3;   // held request, must wait
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("bp latency", seen, 33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid", k),  {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp hold%0d result", k), result,             32'd15);
            chk($sformatf("bp hold%0d ready", k),  {31'd0, in_ready},  32'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp consumed valid", {31'd0, out_valid}, 32'd0);
        chk("bp consumed ready", {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        chk("bp next accepted", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("bp next latency", seen, 33);
        chk("bp next result",  result, 32'd3);
        $display("backpressure sequence: next result 0x%08h after %0d clk", result, seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
